// File: rtl/fxp_pkg.sv
// Shared width helpers and default constants for the fixed-point multiply scheduler.
// The width functions let the top derive W and IDW from its own parameters.
package fxp_pkg;

    localparam int unsigned INTW_DEF = 10;
    localparam int unsigned RATW_DEF = 2;
    localparam int unsigned NREQ_DEF = 4;

    function automatic int unsigned fxp_width(input int unsigned intw, input int unsigned ratw);
        return intw + ratw;
    endfunction

    function automatic int unsigned id_width(input int unsigned nreq);
        return (nreq < 2) ? 1 : $clog2(nreq);
    endfunction

    // Default operand/result width and its saturation value (all ones).
    localparam int unsigned FXP_W   = fxp_width(INTW_DEF, RATW_DEF);
    localparam int unsigned FXP_SAT = (1 << FXP_W) - 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at i_ptr and wraps modulo NREQ.
// It produces a one-hot grant, the encoded index, and a flag that a grant was made.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    always_comb begin
        int j;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        // Walk from the farthest to the nearest slot so that the nearest one is written last.
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            j = (int'(i_ptr) + k) % int'(NREQ);
            if (i_req[j]) begin
                o_grant    = '0;
                o_grant[j] = 1'b1;
                o_idx      = IDW'(j);
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fxp_mul_sched.sv
// Round-robin shared unsigned fixed-point multiplier with a round-half-up and saturation stage.
// A two-stage pipeline with full backpressure returns each result tagged with its requester ID.
module fxp_mul_sched
    import fxp_pkg::*;
#(
    parameter int unsigned INTW = INTW_DEF,
    parameter int unsigned RATW = RATW_DEF,
    parameter int unsigned NREQ = NREQ_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NREQ-1:0]                      req_valid,
    output logic [NREQ-1:0]                      req_ready,
    input  logic [NREQ*fxp_width(INTW,RATW)-1:0] req_a,
    input  logic [NREQ*fxp_width(INTW,RATW)-1:0] req_b,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [fxp_width(INTW,RATW)-1:0]      res_data,
    output logic [id_width(NREQ)-1:0]            res_id
);

    localparam int unsigned W   = fxp_width(INTW, RATW);
    localparam int unsigned IDW = id_width(NREQ);
    localparam int unsigned PW  = 2 * W;
    localparam int unsigned RW  = PW - RATW;
    localparam logic [PW-1:0] HALF = PW'(1) << (RATW - 1);

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gnt_idx;
    logic            w_gnt_any;
    logic            w_s2_adv;
    logic            w_s1_free;
    logic            w_accept;
    logic [W-1:0]    w_op_a;
    logic [W-1:0]    w_op_b;
    logic [RW-1:0]   w_rshift;
    logic [W-1:0]    w_round;

    logic [IDW-1:0]  r_ptr;
    logic            r_s1_valid;
    logic [PW-1:0]   r_s1_prod;
    logic [IDW-1:0]  r_s1_id;
    logic            r_s2_valid;
    logic [W-1:0]    r_s2_data;
    logic [IDW-1:0]  r_s2_id;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gnt_idx),
        .o_any   (w_gnt_any)
    );

    assign w_s2_adv  = !r_s2_valid || res_ready;
    assign w_s1_free = !r_s1_valid || w_s2_adv;
    assign w_accept  = w_gnt_any && w_s1_free && !rst;
    assign req_ready = w_grant & {NREQ{w_s1_free && !rst}};

    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_grant[i]) begin
                w_op_a = req_a[i*W +: W];
                w_op_b = req_b[i*W +: W];
            end
        end
    end

    // Adding half an LSB before the shift is round-half-up; anything left above W bits saturates.
    always_comb begin
        w_rshift = RW'((r_s1_prod + HALF) >> RATW);
        w_round  = (|w_rshift[RW-1:W]) ? '1 : w_rshift[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_id    <= '0;
        end else if (w_s1_free) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_prod <= {{W{1'b0}}, w_op_a} * {{W{1'b0}}, w_op_b};
                r_s1_id   <= w_gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_id    <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_round;
                r_s2_id   <= r_s1_id;
            end
        end
    end

    assign res_valid = r_s2_valid;
    assign res_data  = r_s2_data;
    assign res_id    = r_s2_id;

endmodule

// File: tb/tb_fxp_mul_sched.sv
// Directed and random bench for fxp_mul_sched: vector table, fairness, backpressure, reset, soak.
// A negedge monitor scores every accepted pair against a round-half-up/saturate model.
module tb_fxp_mul_sched;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 12;

    typedef struct {
        int unsigned lane;
        int unsigned a;
        int unsigned b;
        int unsigned exp;
    } vec_t;

    typedef struct {
        int unsigned id;
        int unsigned data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [W-1:0]      res_data;
    logic [1:0]        res_id;

    logic [W-1:0]      a_lane [NREQ];
    logic [W-1:0]      b_lane [NREQ];

    int                total = 0;
    int                bad   = 0;
    int                n_acc = 0;
    int                n_out = 0;
    exp_t              q[$];
    int unsigned       glog[$];
    logic [NREQ-1:0]   acc_vec = '0;
    vec_t              vecs [10];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            req_a[i*W +: W] = a_lane[i];
            req_b[i*W +: W] = b_lane[i];
        end
    end

    fxp_mul_sched #(
        .INTW (10),
        .RATW (2),
        .NREQ (NREQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int unsigned ref_mul(input int unsigned a, input int unsigned b);
        int unsigned r;
        r = (a * b + 2) / 4;
        if (r > 4095) r = 4095;
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        if ($urandom_range(0, 1) == 1) return W'($urandom_range(0, 4095));
        return W'($urandom_range(0, 200));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic            hold_v;
        logic [W-1:0]    hold_d;
        logic [1:0]      hold_id;
        int unsigned     acc0;
        exp_t            e;

        hold_v = 1'b0;
        hold_d = '0;
        hold_id = '0;

        vecs[0] = '{0, 6,    6,    9};
        vecs[1] = '{1, 5,    6,    8};
        vecs[2] = '{2, 4095, 4095, 4095};
        vecs[3] = '{3, 0,    1234, 0};
        vecs[4] = '{0, 7,    2,    4};
        vecs[5] = '{1, 3,    3,    2};
        vecs[6] = '{2, 128,  128,  4095};
        vecs[7] = '{3, 127,  129,  4095};
        vecs[8] = '{0, 127,  128,  4064};
        vecs[9] = '{1, 1,    2,    1};

        // Negedge monitor: logs accepts, scores results, checks hold-stability under stall.
        fork
            forever begin
                @(negedge clk);
                if (rst) begin
                    hold_v  = 1'b0;
                    acc_vec = '0;
                end else begin
                    chk("ready_onehot", ($countones(req_ready) <= 1) ? 1 : 0, 1);
                    acc_vec = req_valid & req_ready;
                    for (int i = 0; i < int'(NREQ); i++) begin
                        if (acc_vec[i]) begin
                            q.push_back('{i, ref_mul(a_lane[i], b_lane[i])});
                            glog.push_back(i);
                            n_acc++;
                        end
                    end
                    if (hold_v) begin
                        chk("stall_valid_held", res_valid, 1);
                        chk("stall_data_stable", res_data, hold_d);
                        chk("stall_id_stable", res_id, hold_id);
                    end
                    if (res_valid && res_ready) begin
                        chk("res_expected_pending", (q.size() > 0) ? 1 : 0, 1);
                        if (q.size() > 0) begin
                            e = q.pop_front();
                            chk("res_data", res_data, e.data);
                            chk("res_id", res_id, e.id);
                        end
                        n_out++;
                    end
                    hold_v  = res_valid && !res_ready;
                    hold_d  = res_data;
                    hold_id = res_id;
                end
            end
        join_none

        // Reset state, with every lane already requesting.
        for (int i = 0; i < int'(NREQ); i++) begin
            a_lane[i] = W'(i + 1);
            b_lane[i] = W'(i + 2);
        end
        req_valid = '1;
        #2;
        chk("reset_res_valid", res_valid, 0);
        chk("reset_res_data", res_data, 0);
        chk("reset_res_id", res_id, 0);
        chk("reset_req_ready", req_ready, 0);
        tick();
        rst = 1'b0;
        res_ready = 1'b1;
        glog.delete();

        // Fairness from reset: 0,1,2,3 repeating, one accept per cycle.
        repeat (8) tick();
        chk("fair_count", glog.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < glog.size()) chk("fair_order", glog[k], k % 4);
        end
        req_valid = 4'b1010;
        glog.delete();
        repeat (4) tick();
        chk("alt_count", glog.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < glog.size()) chk("alt_order", glog[k], (k % 2 == 0) ? 1 : 3);
        end
        req_valid = '0;
        repeat (4) tick();
        chk("fair_drained", q.size(), 0);

        // Directed vectors: value, id and two-cycle latency.
        for (int v = 0; v < 10; v++) begin
            int k;
            a_lane[vecs[v].lane] = W'(vecs[v].a);
            b_lane[vecs[v].lane] = W'(vecs[v].b);
            req_valid = '0;
            req_valid[vecs[v].lane] = 1'b1;
            #1;
            chk("vec_accept", req_ready[vecs[v].lane], 1);
            tick();
            req_valid = '0;
            k = 1;
            while (!res_valid && k < 8) begin
                tick();
                k++;
            end
            chk("vec_latency", k, 2);
            chk("vec_data", res_data, vecs[v].exp);
            chk("vec_id", res_id, vecs[v].lane);
            tick();
        end

        // Backpressure: two accepts fill the pipe, then all ready low.
        for (int i = 0; i < int'(NREQ); i++) begin
            a_lane[i] = W'(10 + i);
            b_lane[i] = W'(20 + i);
        end
        res_ready = 1'b0;
        req_valid = '1;
        glog.delete();
        repeat (5) tick();
        chk("bp_accepts", glog.size(), 2);
        if (glog.size() == 2) chk("bp_order", glog[1], (glog[0] + 1) % 4);
        chk("bp_ready_low", req_ready, 0);
        chk("bp_res_valid", res_valid, 1);
        res_ready = 1'b1;
        #1;
        chk("bp_release_accept", (req_ready != 0) ? 1 : 0, 1);
        tick();
        req_valid = '0;
        repeat (5) tick();
        chk("bp_drained", q.size(), 0);
        chk("bp_no_loss", n_out, n_acc);

        // Reset with both stages full.
        res_ready = 1'b0;
        req_valid = '1;
        repeat (3) tick();
        chk("rst_pre_full", res_valid, 1);
        rst = 1'b1;
        n_acc = n_acc - q.size();
        q.delete();
        #1;
        chk("rst_async_valid", res_valid, 0);
        chk("rst_async_data", res_data, 0);
        chk("rst_async_id", res_id, 0);
        tick();
        req_valid = 4'b1001;
        rst = 1'b0;
        res_ready = 1'b1;
        glog.delete();
        tick();
        req_valid = '0;
        chk("rst_first_grant_n", glog.size(), 1);
        if (glog.size() > 0) chk("rst_first_grant", glog[0], 0);
        repeat (4) tick();
        chk("rst_drained", q.size(), 0);

        // Random soak: requesters hold until accepted, random consumer backpressure.
        acc0 = n_acc;
        for (int c = 0; c < 6000 && (n_acc - acc0) < 1000; c++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (req_valid[i] && acc_vec[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 99) < 60) begin
                    a_lane[i] = rnd_op();
                    b_lane[i] = rnd_op();
                    req_valid[i] = 1'b1;
                end
            end
            res_ready = ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0;
            tick();
        end
        chk("soak_accepts", ((n_acc - acc0) >= 1000) ? 1 : 0, 1);
        for (int c = 0; c < 100 && (req_valid != 0 || q.size() != 0); c++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (req_valid[i] && acc_vec[i]) req_valid[i] = 1'b0;
            end
            res_ready = 1'b1;
            tick();
        end
        chk("soak_lanes_done", req_valid, 0);
        chk("soak_queue_empty", q.size(), 0);
        chk("soak_no_loss", n_out, n_acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
